// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: shares the data-memory/IO bus between the CPU MEM stage (A) and a DMA/debug port (B)
module dmem_bus_arbiter #(
    parameter int RD_LAT   = 1,
    parameter bit CPU_PRIO = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_a_req,
    input  logic        i_a_we,
    input  logic [31:0] i_a_addr,
    input  logic [31:0] i_a_wdata,
    output logic        o_a_ack,
    output logic [31:0] o_a_rdata,
    output logic        o_a_stall,
    input  logic        i_b_req,
    input  logic        i_b_we,
    input  logic [31:0] i_b_addr,
    input  logic [31:0] i_b_wdata,
    output logic        o_b_ack,
    output logic [31:0] o_b_rdata,
    output logic        o_b_stall,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    state_t      r_state, w_next;
    logic        r_win_b, r_last_b, r_we, r_mem_we;
    logic [2:0]  r_cnt;
    logic [31:0] r_mem_addr, r_mem_wdata, r_a_rdata, r_b_rdata;
    logic        w_req, w_grant_b, w_resp;
    assign w_req = i_a_req | i_b_req;
    // B wins when A is absent, or on a round-robin tie where A was served last
    assign w_grant_b = ~(i_a_req & (~i_b_req | CPU_PRIO | r_last_b));
    assign w_resp = r_state == S_RESP;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_we = r_mem_we;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_req ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = (RD_LAT == 0) ? S_RESP : S_WAIT;
            S_WAIT:  w_next = (r_cnt == 3'd1) ? S_RESP : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end
    always_comb begin
        o_a_ack = w_resp & ~r_win_b;
        o_b_ack = w_resp & r_win_b;
        o_a_rdata = (o_a_ack & ~r_we) ? i_mem_rdata : r_a_rdata;
        o_b_rdata = (o_b_ack & ~r_we) ? i_mem_rdata : r_b_rdata;
        o_a_stall = i_rst_n & i_a_req & ~o_a_ack;
        o_b_stall = i_rst_n & i_b_req & ~o_b_ack;
        o_busy = r_state != S_IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_win_b <= 1'b0;
            r_last_b <= 1'b1;
            r_we <= 1'b0;
            r_mem_we <= 1'b0;
            r_cnt <= 3'd0;
            r_mem_addr <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_a_rdata <= 32'd0;
            r_b_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_mem_we <= 1'b0;
            if (r_state == S_IDLE && w_req) begin
                r_win_b <= w_grant_b;
                r_we <= w_grant_b ? i_b_we : i_a_we;
                r_mem_we <= w_grant_b ? i_b_we : i_a_we;
                r_mem_addr <= w_grant_b ? i_b_addr : i_a_addr;
                r_mem_wdata <= w_grant_b ? i_b_wdata : i_a_wdata;
            end
            if (r_state == S_ISSUE) r_cnt <= 3'(RD_LAT);
            if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
            if (w_resp) begin
                r_last_b <= r_win_b;
                if (!r_we && !r_win_b) r_a_rdata <= i_mem_rdata;
                if (!r_we && r_win_b) r_b_rdata <= i_mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb_dmem_bus_arbiter: random two-master traffic against a transaction-schedule model, round-robin and fixed-priority builds
module tb_dmem_bus_arbiter;
    logic clk = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 0;
        logic        rst_n = 1'b1;
        logic        done = 1'b0;
        logic        a_req, a_we, b_req, b_we, a_ack, b_ack, a_stall, b_stall, mem_we, busy;
        logic [31:0] a_addr, a_wdata, b_addr, b_wdata, a_rdata, b_rdata;
        logic [31:0] mem_addr, mem_wdata, mem_rdata;
        logic [31:0] bus_mem [256];
        logic [31:0] ref_mem [256];
        assign mem_rdata = bus_mem[mem_addr[7:0]];
        dmem_bus_arbiter #(.RD_LAT(LAT), .CPU_PRIO(g == 1)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n),
            .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
            .o_a_ack(a_ack), .o_a_rdata(a_rdata), .o_a_stall(a_stall),
            .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
            .o_b_ack(b_ack), .o_b_rdata(b_rdata), .o_b_stall(b_stall),
            .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
            .i_mem_rdata(mem_rdata), .o_busy(busy)
        );
        task automatic chk_zero();
            check("rst_a_ack", 32'(a_ack), 0);
            check("rst_b_ack", 32'(b_ack), 0);
            check("rst_a_stall", 32'(a_stall), 0);
            check("rst_b_stall", 32'(b_stall), 0);
            check("rst_mem_we", 32'(mem_we), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_a_rdata", a_rdata, 0);
            check("rst_b_rdata", b_rdata, 0);
        endtask
        initial begin
            int t0;
            bit act, win_b, t_we, last_b, did_rst, ap, ad, bp, bd, b_used, e_aack, e_back, resp;
            logic [31:0] t_addr, t_wdata, ra, rb, e_addr, e_wdata;
            for (int i = 0; i < 256; i++) begin
                bus_mem[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5a, 8'hc3};
                ref_mem[i] = bus_mem[i];
            end
            bus_mem[8'h80] = 32'h12345678;
            ref_mem[8'h80] = 32'h12345678;
            t0 = 0; act = 0; win_b = 0; t_we = 0; last_b = 1; did_rst = 0; b_used = 0;
            e_aack = 0; e_back = 0; t_addr = 0; t_wdata = 0; ra = 0; rb = 0; e_addr = 0; e_wdata = 0;
            ap = 1; ad = 0; bp = 0; bd = 0;
            a_we = 1; a_addr = 32'h10; a_wdata = 32'hdeadbeef;
            b_we = 0; b_addr = 32'h80; b_wdata = 0;
            a_req = 0; b_req = 0;
            #3 rst_n = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk_zero();
            rst_n = 1'b1;
            for (int n = 0; n < 700; n++) begin
                if (!did_rst && n >= 300 && act && n == t0 + 2) begin
                    rst_n = 1'b0;
                    #1 chk_zero();
                    ap = ap && !ad; bp = bp && !bd; ad = 0; bd = 0;
                    act = 0; last_b = 1; ra = 0; rb = 0; e_addr = 0; e_wdata = 0;
                    e_aack = 0; e_back = 0; did_rst = 1;
                    @(negedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                if (e_aack) begin ap = 0; ad = 0; end
                if (e_back) begin bp = 0; bd = 0; end
                if (act && ap && !win_b && $urandom_range(15) == 0) ad = 1;
                if (act && bp && win_b && $urandom_range(15) == 0) bd = 1;
                if (act && n > 0 && $urandom_range(3) == 0) begin
                    a_addr = $urandom; a_wdata = $urandom; b_addr = $urandom; b_wdata = $urandom;
                end
                if (!ap && $urandom_range(3) == 0) begin
                    ap = 1; a_we = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
                end
                if (!bp && $urandom_range(3) == 0) begin
                    bp = 1; b_we = 1'($urandom); b_addr = $urandom; b_wdata = $urandom;
                    if (!b_used) begin b_we = 0; b_addr = 32'h80; b_used = 1; end
                end
                a_req = ap && !ad;
                b_req = bp && !bd;
                #1;
                if (act && n > t0 + 2 + LAT) act = 0;
                if (!act && (a_req || b_req)) begin
                    act = 1; t0 = n;
                    win_b = !(a_req && (!b_req || g == 1 || last_b));
                    t_we = win_b ? b_we : a_we;
                    t_addr = win_b ? b_addr : a_addr;
                    t_wdata = win_b ? b_wdata : a_wdata;
                end
                if (act && n == t0 + 1) begin
                    e_addr = t_addr; e_wdata = t_wdata;
                    if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
                end
                resp = act && n == t0 + 2 + LAT;
                e_aack = resp && !win_b;
                e_back = resp && win_b;
                if (resp && !t_we && win_b) rb = ref_mem[t_addr[7:0]];
                if (resp && !t_we && !win_b) ra = ref_mem[t_addr[7:0]];
                if (resp) last_b = win_b;
                check("a_ack", 32'(a_ack), 32'(e_aack));
                check("b_ack", 32'(b_ack), 32'(e_back));
                check("busy", 32'(busy), 32'(act && n > t0));
                check("mem_we", 32'(mem_we), 32'(act && n == t0 + 1 && t_we));
                check("mem_addr", mem_addr, e_addr);
                check("mem_wdata", mem_wdata, e_wdata);
                check("a_rdata", a_rdata, ra);
                check("b_rdata", b_rdata, rb);
                check("a_stall", 32'(a_stall), 32'(a_req && !e_aack));
                check("b_stall", 32'(b_stall), 32'(b_req && !e_back));
                if (mem_we) bus_mem[mem_addr[7:0]] = mem_wdata;
                @(negedge clk);
            end
            check("reset_hit", 32'(did_rst), 1);
            done = 1'b1;
        end
    end
    initial begin
        wait (g_dut[0].done && g_dut[1].done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
